mem_responder: RTL

Synthesizable memory-side responder for the processor's 8-bit-address / 16-bit-data memory interface, the counterpart of the processor's memory initiator port. It holds a 256-word RAM and answers processor reads and writes. It also owns a host preload port that fills program memory while the processor is held. It sits on the board/FPGA side of the bus; tristate muxing of the shared MemData bus is done outside this block.

---
 rtl/mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: 2^AW x DW RAM with host preload (CLEAR -> LOAD -> RUN).
// Optional write protection of addresses below PROT_LIMIT via `MEM_WRITE_PROTECT_EN.
module mem_responder #(
  parameter int unsigned    AW             = 8,
  parameter int unsigned    DW             = 16,
  parameter bit             CLEAR_ON_RESET = 1'b1,
  parameter logic [AW-1:0]  PROT_LIMIT     = AW'('h10)
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] Adr,
  input  logic [DW-1:0] WData,
  output logic [DW-1:0] RData,
  output logic          cpu_hold,
  output logic          ready,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_adr,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  output logic [15:0]   wr_count,
  output logic          wp_err
);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

  localparam int unsigned  DEPTH       = 1 << AW;
  localparam logic [AW:0]  CLR_LAST    = (AW+1)'(DEPTH - 1);
  localparam state_t       RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t        state, state_nx;
  logic [AW:0]   clr_cnt;
  logic          armed;
  logic [DW-1:0] mem [DEPTH];

  logic          load_fire, run_wr, wp_hit, wr_ok;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  // armed keeps load_ready low while reset holds the FSM in LOAD
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLEAR: if (clr_cnt == CLR_LAST)       state_nx = ST_LOAD;
      ST_LOAD:  if (load_ready && load_done)   state_nx = ST_RUN;
      ST_RUN:   state_nx = ST_RUN;
      default:  state_nx = RESET_STATE;
    endcase
  end

  always_comb begin
    cpu_hold   = (state != ST_RUN);
    ready      = (state == ST_RUN);
    load_ready = armed && (state == ST_LOAD);
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)                 clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + (AW+1)'(1);
  end

  assign load_fire = load_ready && load_valid;
  assign run_wr    = ready && MemWrite;
  assign wp_hit    = WP_EN && (Adr < PROT_LIMIT);
  assign wr_ok     = run_wr && !wp_hit;

  // Single write port shared by clear, host load and processor writes
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_cnt[AW-1:0];
    mem_wd = '0;
    unique case (state)
      ST_CLEAR: mem_we = 1'b1;
      ST_LOAD: begin
        mem_we = load_fire;
        mem_wa = load_adr;
        mem_wd = load_data;
      end
      ST_RUN: begin
        mem_we = wr_ok;
        mem_wa = Adr;
        mem_wd = WData;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read samples the pre-write contents, so same-edge write+read returns the old word
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)     RData <= '0;
    else if (ready) RData <= mem[Adr];
    else            RData <= '0;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)                          wr_count <= '0;
    else if (wr_ok && (wr_count != '1))  wr_count <= wr_count + 16'd1;
  end

`ifdef MEM_WRITE_PROTECT_EN
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)                wp_err <= 1'b0;
    else if (run_wr && wp_hit) wp_err <= 1'b1;
  end
`else
  assign wp_err = 1'b0;
`endif

endmodule
